// File: rtl/pipelined_add_sub_if.sv
// Valid/ready operand and result bundle for the pipelined adder/subtractor.
// The master drives operations and output ready; the slave returns results.
interface pipelined_add_sub_if #(
  parameter int WIDTH = 16
);
  logic             in_valid;
  logic             in_ready;
  logic [WIDTH-1:0] a;
  logic [WIDTH-1:0] b;
  logic             sub;
  logic             c_in;
  logic             out_valid;
  logic             out_ready;
  logic [WIDTH-1:0] sum;
  logic             c_out;
  logic             ovf;

  modport master (
    output in_valid, a, b, sub, c_in, out_ready,
    input  in_ready, out_valid, sum, c_out, ovf
  );

  modport slave (
    input  in_valid, a, b, sub, c_in, out_ready,
    output in_ready, out_valid, sum, c_out, ovf
  );
endinterface

// File: rtl/pipelined_add_sub.sv
// Pipelined ripple-carry adder/subtractor, one CHUNK-bit slice per stage.
// Unconsumed operand bits and finished sum bits are skewed along the pipe.
module pipelined_add_sub #(
  parameter int WIDTH = 16,
  parameter int CHUNK = 4
) (
  input logic               clock,
  input logic               reset_n,
  pipelined_add_sub_if.slave bus
);
  localparam int STAGES = WIDTH / CHUNK;

  logic              en;
  logic [STAGES-1:0] v_q, v_d;
  logic [STAGES-1:0] c_q, c_d;
  logic [STAGES-1:0] o_q, o_d;
  logic [WIDTH-1:0]  a_q [STAGES];
  logic [WIDTH-1:0]  a_d [STAGES];
  logic [WIDTH-1:0]  b_q [STAGES];
  logic [WIDTH-1:0]  b_d [STAGES];
  logic [WIDTH-1:0]  s_q [STAGES];
  logic [WIDTH-1:0]  s_d [STAGES];

  // No bubble collapsing: the whole pipe advances or holds together.
  assign en           = ~v_q[STAGES-1] | bus.out_ready;
  assign bus.in_ready = en;

  for (genvar k = 0; k < STAGES; k++) begin : g_st
    localparam int LO = k * CHUNK;
    localparam logic [WIDTH-1:0] MASK =
      WIDTH'({CHUNK{1'b1}}) << LO;

    logic [WIDTH-1:0] ai;
    logic [WIDTH-1:0] bi;
    logic [WIDTH-1:0] si;
    logic             ci;
    logic             vi;
    logic [CHUNK:0]   part;
    logic             cm;

    if (k == 0) begin : g_first
      // Subtract as a + ~b + 1; c_in only matters when adding.
      assign ai = bus.a;
      assign bi = bus.sub ? ~bus.b : bus.b;
      assign ci = bus.sub | bus.c_in;
      assign si = '0;
      assign vi = bus.in_valid;
    end else begin : g_next
      assign ai = a_q[k-1];
      assign bi = b_q[k-1];
      assign ci = c_q[k-1];
      assign si = s_q[k-1];
      assign vi = v_q[k-1];
    end

    assign part = {1'b0, ai[LO +: CHUNK]}
                + {1'b0, bi[LO +: CHUNK]}
                + (CHUNK+1)'(ci);

    // Carry into this slice's MSB, recovered from the sum bit.
    assign cm = ai[LO+CHUNK-1]
              ^ bi[LO+CHUNK-1]
              ^ part[CHUNK-1];

    assign a_d[k] = ai;
    assign b_d[k] = bi;
    assign s_d[k] = (si & ~MASK)
                  | (WIDTH'(part[CHUNK-1:0]) << LO);
    assign c_d[k] = part[CHUNK];
    assign o_d[k] = cm ^ part[CHUNK];
    assign v_d[k] = vi;
  end

  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) begin
      v_q <= '0;
      c_q <= '0;
      o_q <= '0;
      for (int k = 0; k < STAGES; k++) begin
        a_q[k] <= '0;
        b_q[k] <= '0;
        s_q[k] <= '0;
      end
    end else if (en) begin
      v_q <= v_d;
      c_q <= c_d;
      o_q <= o_d;
      for (int k = 0; k < STAGES; k++) begin
        a_q[k] <= a_d[k];
        b_q[k] <= b_d[k];
        s_q[k] <= s_d[k];
      end
    end
  end

  assign bus.out_valid = v_q[STAGES-1];
  assign bus.sum       = s_q[STAGES-1];
  assign bus.c_out     = c_q[STAGES-1];
  assign bus.ovf       = o_q[STAGES-1];
endmodule

// File: tb/tb_pipelined_add_sub.sv
// Directed bench: 16-bit/4-bit-chunk and 4-bit/1-bit-chunk instances
// exercising latency, wrap, overflow, backpressure and mid-flight reset.
module tb_pipelined_add_sub;
  logic clock;
  logic reset_n;
  int   compared;
  int   mism;

  pipelined_add_sub_if #(.WIDTH(16)) if16 ();
  pipelined_add_sub_if #(.WIDTH(4))  if4 ();

  pipelined_add_sub #(.WIDTH(16), .CHUNK(4)) dut16 (
    .clock   (clock),
    .reset_n (reset_n),
    .bus     (if16)
  );

  pipelined_add_sub #(.WIDTH(4), .CHUNK(1)) dut4 (
    .clock   (clock),
    .reset_n (reset_n),
    .bus     (if4)
  );

  initial begin
    clock = 1'b0;
    forever #5 clock = ~clock;
  end

  task automatic chk(input string tag,
                     input logic [31:0] obs,
                     input logic [31:0] exp);
    compared++;
    assert (obs === exp) else begin
      mism++;
      $error("FAIL %s: observed %h expected %h",
             tag, obs, exp);
    end
  endtask

  task automatic tick();
    @(posedge clock);
    #1;
  endtask

  function automatic logic [17:0] model16(
    input logic [15:0] a, input logic [15:0] b,
    input logic sub, input logic cin);
    logic [15:0] bb;
    logic [16:0] r;
    logic        ov;
    bb = sub ? ~b : b;
    r  = {1'b0, a} + {1'b0, bb} + 17'(sub | cin);
    ov = (a[15] == bb[15]) && (r[15] != a[15]);
    return {ov, r};
  endfunction

  logic [17:0] q[$];
  int          sent;
  int          got;

  initial begin
    compared = 0;
    mism     = 0;
    reset_n  = 1'b0;
    if16.in_valid  = 1'b0;
    if16.a         = '0;
    if16.b         = '0;
    if16.sub       = 1'b0;
    if16.c_in      = 1'b0;
    if16.out_ready = 1'b1;
    if4.in_valid   = 1'b0;
    if4.a          = '0;
    if4.b          = '0;
    if4.sub        = 1'b0;
    if4.c_in       = 1'b0;
    if4.out_ready  = 1'b1;

    // 1: reset
    repeat (3) @(posedge clock);
    #1 reset_n = 1'b1;
    #1;
    chk("rst_ov16", 32'(if16.out_valid), 32'd0);
    chk("rst_sum16", 32'(if16.sum), 32'd0);
    chk("rst_cout16", 32'(if16.c_out), 32'd0);
    chk("rst_ovf16", 32'(if16.ovf), 32'd0);
    chk("rst_ir16", 32'(if16.in_ready), 32'd1);
    chk("rst_ov4", 32'(if4.out_valid), 32'd0);

    // 2: single add, latency STAGES-1 after accept edge
    if16.in_valid = 1'b1;
    if16.a = 16'h00FF;
    if16.b = 16'h0001;
    tick();
    if16.in_valid = 1'b0;
    tick();
    tick();
    chk("t2_early", 32'(if16.out_valid), 32'd0);
    tick();
    chk("t2_ov", 32'(if16.out_valid), 32'd1);
    chk("t2_sum", 32'(if16.sum), 32'h0100);
    chk("t2_cout", 32'(if16.c_out), 32'd0);
    chk("t2_ovf", 32'(if16.ovf), 32'd0);
    tick();
    chk("t2_gone", 32'(if16.out_valid), 32'd0);

    // 3: 4-bit ripple, back-to-back
    if4.in_valid = 1'b1;
    if4.a = 4'd9;  if4.b = 4'd9;  if4.c_in = 1'b0;
    tick();
    if4.a = 4'd10; if4.b = 4'd15; if4.c_in = 1'b0;
    tick();
    if4.a = 4'd10; if4.b = 4'd5;  if4.c_in = 1'b1;
    tick();
    if4.in_valid = 1'b0;
    if4.c_in = 1'b0;
    tick();
    chk("t3_r0", 32'({if4.out_valid, if4.ovf, if4.c_out, if4.sum}),
        32'b1_1_1_0010);
    tick();
    chk("t3_r1", 32'({if4.out_valid, if4.ovf, if4.c_out, if4.sum}),
        32'b1_0_1_1001);
    tick();
    chk("t3_r2", 32'({if4.out_valid, if4.ovf, if4.c_out, if4.sum}),
        32'b1_0_1_0000);
    tick();
    chk("t3_end", 32'(if4.out_valid), 32'd0);

    // 4: subtract, c_in ignored in sub mode
    if16.in_valid = 1'b1;
    if16.sub = 1'b1;
    if16.c_in = 1'b1;
    if16.a = 16'h8000; if16.b = 16'h0001;
    tick();
    if16.c_in = 1'b0;
    if16.a = 16'h0000; if16.b = 16'h0001;
    tick();
    if16.in_valid = 1'b0;
    if16.sub = 1'b0;
    tick();
    tick();
    chk("t4_r0", 32'({if16.out_valid, if16.ovf, if16.c_out, if16.sum}),
        {13'd0, 1'b1, 1'b1, 1'b1, 16'h7FFF});
    tick();
    chk("t4_r1", 32'({if16.out_valid, if16.ovf, if16.c_out, if16.sum}),
        {13'd0, 1'b1, 1'b0, 1'b0, 16'hFFFF});
    tick();

    // 5: stream 6 ops with a 3-cycle output stall
    sent = 0;
    got  = 0;
    for (int cyc = 0; cyc < 24; cyc++) begin
      if16.in_valid  = (sent < 6);
      if16.a         = 16'(32'h1357 * (sent + 3));
      if16.b         = 16'(32'h0FED * (sent + 1));
      if16.sub       = sent[0];
      if16.c_in      = sent[1];
      if16.out_ready = !(cyc >= 4 && cyc < 7);
      #1;
      chk("t5_ir", 32'(if16.in_ready),
          32'(!if16.out_valid || if16.out_ready));
      if (if16.out_valid) begin
        if (q.size() == 0) begin
          chk("t5_extra", 32'(if16.out_valid), 32'd0);
        end else begin
          chk("t5_res", 32'({if16.ovf, if16.c_out, if16.sum}),
              32'(q[0]));
          if (if16.out_ready) begin
            void'(q.pop_front());
            got++;
          end
        end
      end
      if (if16.in_valid && if16.in_ready) begin
        q.push_back(model16(if16.a, if16.b,
                            if16.sub, if16.c_in));
        sent++;
      end
      @(posedge clock);
      #1;
    end
    chk("t5_count", 32'(got), 32'd6);
    if16.in_valid  = 1'b0;
    if16.sub       = 1'b0;
    if16.c_in      = 1'b0;
    if16.out_ready = 1'b1;

    // 6: reset pulse with three ops in flight
    for (int i = 0; i < 3; i++) begin
      if16.in_valid = 1'b1;
      if16.a = 16'(i + 1);
      if16.b = 16'h0100;
      tick();
    end
    reset_n = 1'b0;
    if16.in_valid = 1'b0;
    #1;
    chk("t6_rst_ov", 32'(if16.out_valid), 32'd0);
    tick();
    reset_n = 1'b1;
    for (int i = 0; i < 6; i++) begin
      tick();
      chk("t6_quiet", 32'(if16.out_valid), 32'd0);
    end
    if16.in_valid = 1'b1;
    if16.a = 16'h1234;
    if16.b = 16'h1111;
    tick();
    if16.in_valid = 1'b0;
    repeat (3) tick();
    chk("t6_new", 32'({if16.out_valid, if16.sum}),
        32'h1_2345);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***",
             compared, mism);
    $finish;
  end
endmodule
